// File: rtl/sap_ctrl_seq_if.sv
// Control/status bundle between the SAP sequencer (slave side) and the datapath it steers (master side).
interface sap_ctrl_seq_if #(
  parameter int unsigned CNT_W = 8
);
  logic [3:0]       opcode;
  logic             pc_oe;
  logic             pc_inc;
  logic             mar_load;
  logic             ram_oe;
  logic             ir_load;
  logic             ir_oe;
  logic             a_load;
  logic             a_oe;
  logic             b_load;
  logic             alu_sub;
  logic             alu_oe;
  logic             out_load;
  logic             halted;
  logic [5:0]       tstate;
  logic [CNT_W-1:0] instr_cnt;

  modport slave (
    input  opcode,
    output pc_oe, pc_inc, mar_load, ram_oe, ir_load, ir_oe, a_load, a_oe,
           b_load, alu_sub, alu_oe, out_load, halted, tstate, instr_cnt
  );

  modport master (
    output opcode,
    input  pc_oe, pc_inc, mar_load, ram_oe, ir_load, ir_oe, a_load, a_oe,
           b_load, alu_sub, alu_oe, out_load, halted, tstate, instr_cnt
  );
endinterface

// File: rtl/sap_ctrl_seq.sv
// SAP-1 controller-sequencer: six-state ring counter, control-word decode, halt and retired count.
// Optional SAP_SINGLE_STEP_EN adds a step input that gates every state change.
module sap_ctrl_seq #(
  parameter int unsigned CNT_W = 8
) (
  input  logic          clk,
  input  logic          clr_n,
`ifdef SAP_SINGLE_STEP_EN
  input  logic          step,
`endif
  sap_ctrl_seq_if.slave bus
);

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [5:0] {
    ST_HALT = 6'b000000,
    ST_T1   = 6'b000001,
    ST_T2   = 6'b000010,
    ST_T3   = 6'b000100,
    ST_T4   = 6'b001000,
    ST_T5   = 6'b010000,
    ST_T6   = 6'b100000
  } state_e;

  state_e           state_q, state_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             adv_c;

`ifdef SAP_SINGLE_STEP_EN
  assign adv_c = step;
`else
  assign adv_c = 1'b1;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= ST_T1;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and control-word decode; opcode only matters in T4-T6.
  always_comb begin
    state_d      = state_q;
    halted_d     = halted_q;
    cnt_d        = cnt_q;
    bus.pc_oe    = 1'b0;
    bus.pc_inc   = 1'b0;
    bus.mar_load = 1'b0;
    bus.ram_oe   = 1'b0;
    bus.ir_load  = 1'b0;
    bus.ir_oe    = 1'b0;
    bus.a_load   = 1'b0;
    bus.a_oe     = 1'b0;
    bus.b_load   = 1'b0;
    bus.alu_sub  = 1'b0;
    bus.alu_oe   = 1'b0;
    bus.out_load = 1'b0;

    case (state_q)
      ST_T1: begin
        bus.pc_oe    = 1'b1;
        bus.mar_load = 1'b1;
        if (adv_c) state_d = ST_T2;
      end
      ST_T2: begin
        bus.pc_inc = 1'b1;
        if (adv_c) state_d = ST_T3;
      end
      ST_T3: begin
        bus.ram_oe  = 1'b1;
        bus.ir_load = 1'b1;
        if (adv_c) state_d = ST_T4;
      end
      ST_T4: begin
        case (bus.opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            bus.ir_oe    = 1'b1;
            bus.mar_load = 1'b1;
          end
          OP_OUT: begin
            bus.a_oe     = 1'b1;
            bus.out_load = 1'b1;
          end
          default: ;
        endcase
        if (adv_c) begin
          if (bus.opcode == OP_HLT) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            state_d = ST_T5;
          end
        end
      end
      ST_T5: begin
        case (bus.opcode)
          OP_LDA: begin
            bus.ram_oe = 1'b1;
            bus.a_load = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            bus.ram_oe = 1'b1;
            bus.b_load = 1'b1;
          end
          default: ;
        endcase
        if (adv_c) state_d = ST_T6;
      end
      ST_T6: begin
        if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
          bus.alu_oe  = 1'b1;
          bus.alu_sub = (bus.opcode == OP_SUB);
          bus.a_load  = 1'b1;
        end
        if (adv_c) begin
          state_d = ST_T1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_HALT: ;
      default: state_d = ST_T1;
    endcase
  end

  assign bus.tstate    = state_q;
  assign bus.halted    = halted_q;
  assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_sap_ctrl_seq.sv
// Randomized and directed checks of sap_ctrl_seq against an instruction-level reference model.
module tb_sap_ctrl_seq;

  localparam int unsigned CNT_W = 8;
  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  logic clk;
  logic clr_n;
`ifdef SAP_SINGLE_STEP_EN
  logic step;
`endif

  sap_ctrl_seq_if #(.CNT_W(CNT_W)) bus ();

  sap_ctrl_seq #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .clr_n (clr_n),
`ifdef SAP_SINGLE_STEP_EN
    .step  (step),
`endif
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: which step (1..6) of the instruction we are in, halt flag, retired count.
  int m_t;
  bit m_halt;
  int m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] exp_ctrl(input int t, input bit halt, input logic [3:0] op);
    bit mem_op, alu_op;
    logic pc_oe, pc_inc, mar_load, ram_oe, ir_load, ir_oe;
    logic a_load, a_oe, b_load, alu_sub, alu_oe, out_load;
    mem_op = (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
    alu_op = (op == OP_ADD) || (op == OP_SUB);
    {pc_oe, pc_inc, mar_load, ram_oe, ir_load, ir_oe} = '0;
    {a_load, a_oe, b_load, alu_sub, alu_oe, out_load} = '0;
    if (!halt) begin
      if (t == 1) begin pc_oe = 1; mar_load = 1; end
      if (t == 2) pc_inc = 1;
      if (t == 3) begin ram_oe = 1; ir_load = 1; end
      if (t == 4 && mem_op) begin ir_oe = 1; mar_load = 1; end
      if (t == 4 && op == OP_OUT) begin a_oe = 1; out_load = 1; end
      if (t == 5 && mem_op) begin
        ram_oe = 1;
        if (op == OP_LDA) a_load = 1; else b_load = 1;
      end
      if (t == 6 && alu_op) begin alu_oe = 1; a_load = 1; alu_sub = (op == OP_SUB); end
    end
    return {pc_oe, pc_inc, mar_load, ram_oe, ir_load, ir_oe,
            a_load, a_oe, b_load, alu_sub, alu_oe, out_load};
  endfunction

  task automatic model_reset();
    m_t = 1; m_halt = 0; m_cnt = 0;
  endtask

  task automatic model_advance(input logic [3:0] op, input logic st);
    if (m_halt || !st) return;
    if (m_t == 4 && op == OP_HLT) m_halt = 1;
    else if (m_t == 6) begin m_t = 1; m_cnt = (m_cnt + 1) % (1 << CNT_W); end
    else m_t++;
  endtask

  task automatic check_all();
    logic [11:0] got;
    int oe_cnt;
    got = {bus.pc_oe, bus.pc_inc, bus.mar_load, bus.ram_oe, bus.ir_load, bus.ir_oe,
           bus.a_load, bus.a_oe, bus.b_load, bus.alu_sub, bus.alu_oe, bus.out_load};
    oe_cnt = int'(bus.pc_oe) + int'(bus.ram_oe) + int'(bus.ir_oe) + int'(bus.a_oe) + int'(bus.alu_oe);
    chk("tstate", 32'(bus.tstate), m_halt ? 32'd0 : 32'(1) << (m_t - 1));
    chk("halted", 32'(bus.halted), 32'(m_halt));
    chk("instr_cnt", 32'(bus.instr_cnt), 32'(m_cnt));
    chk("ctrl", 32'(got), 32'(exp_ctrl(m_t, m_halt, bus.opcode)));
    chk("oe_excl", 32'(oe_cnt <= 1), 32'd1);
  endtask

  // Inputs change at the falling edge; outputs are checked 1 ns later.
  task automatic do_cycle(input logic [3:0] op, input logic st);
    bus.opcode = op;
`ifdef SAP_SINGLE_STEP_EN
    step = st;
`endif
    #1;
    check_all();
    @(posedge clk);
    model_advance(op, st);
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [3:0] op);
    for (int i = 0; i < 6; i++)
      do_cycle((i < 3) ? 4'($urandom_range(0, 15)) : op, 1'b1);
  endtask

  task automatic apply_reset();
    clr_n = 1'b0;
    bus.opcode = 4'($urandom_range(0, 15));
`ifdef SAP_SINGLE_STEP_EN
    step = 1'b0;
`endif
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    #1;
    check_all();
    clr_n = 1'b1;
  endtask

  initial begin
    int saved_cnt;
    model_reset();
    apply_reset();

    // Directed instructions
    run_instr(OP_LDA);
    chk("cnt_after_lda", 32'(bus.instr_cnt), 32'd1);
    run_instr(OP_SUB);
    run_instr(OP_ADD);
    run_instr(4'b0101);
    run_instr(OP_OUT);

    // Asynchronous reset in the middle of T5
    for (int i = 0; i < 4; i++) do_cycle((i < 3) ? 4'($urandom_range(0, 15)) : OP_ADD, 1'b1);
    chk("pre_rst_t5", 32'(bus.tstate), 32'h10);
    #2 clr_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    clr_n = 1'b1;

    // Long random run: ignored fetch opcodes, random execute opcodes, counter wrap
    for (int i = 0; i < 2400; i++) begin
`ifdef SAP_SINGLE_STEP_EN
      do_cycle(4'($urandom_range(0, 14)), 1'($urandom_range(0, 7) != 0));
`else
      do_cycle(4'($urandom_range(0, 14)), 1'b1);
`endif
    end
    for (int i = 0; i < 12 && m_t != 1; i++) do_cycle(4'($urandom_range(0, 14)), 1'b1);
    chk("aligned_t1", 32'(bus.tstate), 32'h01);

    // OUT then HLT, then stay frozen
    run_instr(OP_OUT);
    saved_cnt = m_cnt;
    run_instr(OP_HLT);
    for (int i = 0; i < 20; i++) do_cycle(4'($urandom_range(0, 15)), 1'b1);
    chk("halt_cnt_frozen", 32'(bus.instr_cnt), 32'(saved_cnt));
    chk("halt_flag", 32'(bus.halted), 32'd1);

    apply_reset();
    run_instr(OP_LDA);

`ifdef SAP_SINGLE_STEP_EN
    // Step held low keeps the state; a single pulse moves exactly one state
    for (int i = 0; i < 10; i++) do_cycle(4'($urandom_range(0, 15)), 1'b0);
    do_cycle(4'($urandom_range(0, 15)), 1'b1);
    chk("single_step", 32'(bus.tstate), 32'h02);
    for (int i = 0; i < 3; i++) do_cycle(4'($urandom_range(0, 15)), 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
